// File: rtl/bf16_pkg.sv
// Shared opcodes, flag positions and NaN classification for the BF16 support unit.
package bf16_pkg;

    localparam logic [3:0] OP_CVT = 4'b0000;
    localparam logic [3:0] OP_MIN = 4'b0010;
    localparam logic [3:0] OP_MAX = 4'b0011;
    localparam logic [3:0] OP_FEQ = 4'b0100;
    localparam logic [3:0] OP_FLT = 4'b0101;
    localparam logic [3:0] OP_FLE = 4'b0110;

    localparam int FL_NV = 3;
    localparam int FL_OF = 2;
    localparam int FL_UF = 1;
    localparam int FL_NX = 0;

    localparam logic [15:0] BF16_CANON_NAN = 16'h7FC0;

    function automatic logic is_nan(input logic [15:0] x);
        return (x[14:7] == 8'hFF) && (x[6:0] != 7'd0);
    endfunction

    function automatic logic is_snan(input logic [15:0] x);
        return is_nan(x) && !x[6];
    endfunction

endpackage

// File: rtl/bf16_cmp_unit.sv
// Combinational BF16 ordering: min/max selection and FEQ/FLT/FLE with their NV flags.
module bf16_cmp_unit
    import bf16_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [3:0]  op,
    output logic [15:0] minmax,
    output logic        minmax_nv,
    output logic        cmp_true,
    output logic        cmp_nv
);

    logic [15:0] key_a;
    logic [15:0] key_b;
    logic        a_nan;
    logic        b_nan;
    logic        any_nan;
    logic        any_snan;
    logic        key_lt;
    logic        both_zero;
    logic        lt;
    logic        eq;

    // Sign-magnitude mapped to an unsigned total order; -0 sorts just below +0.
    assign key_a     = a[15] ? ~a : (a | 16'h8000);
    assign key_b     = b[15] ? ~b : (b | 16'h8000);
    assign key_lt    = key_a < key_b;
    assign a_nan     = is_nan(a);
    assign b_nan     = is_nan(b);
    assign any_nan   = a_nan || b_nan;
    assign any_snan  = is_snan(a) || is_snan(b);
    assign both_zero = (a[14:0] == 15'd0) && (b[14:0] == 15'd0);
    assign lt        = key_lt && !both_zero;
    assign eq        = (a == b) || both_zero;

    always_comb begin
        minmax    = 16'h0000;
        minmax_nv = any_snan;
        cmp_true  = 1'b0;
        cmp_nv    = 1'b0;
        if (a_nan && b_nan) begin
            minmax = BF16_CANON_NAN;
        end else if (a_nan) begin
            minmax = b;
        end else if (b_nan) begin
            minmax = a;
        end else if (op == OP_MAX) begin
            minmax = key_lt ? b : a;
        end else begin
            minmax = key_lt ? a : b;
        end
        case (op)
            OP_FEQ: begin
                cmp_true = !any_nan && eq;
                cmp_nv   = any_snan;
            end
            OP_FLT: begin
                cmp_true = !any_nan && lt;
                cmp_nv   = any_nan;
            end
            OP_FLE: begin
                cmp_true = !any_nan && (lt || eq);
                cmp_nv   = any_nan;
            end
            default: begin
                cmp_true = 1'b0;
                cmp_nv   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/bf16_accelerator_top.sv
// BF16 support unit: FP32->BF16 RNE conversion, min/max and compares, one-cycle registered result.
module bf16_accelerator_top
    import bf16_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] operand_a,
    input  logic [15:0] operand_b,
    input  logic [31:0] operand_c,
    input  logic [3:0]  operation,
    output logic [15:0] result,
    output logic [3:0]  fpcsr,
    output logic        valid
);

    // Returns {flags, bf16}; a mantissa carry simply ripples into the exponent field.
    function automatic logic [19:0] cvt_round(input logic [31:0] f);
        logic [14:0] mag;
        logic        up;
        logic        nx;
        logic [3:0]  fl;
        logic [15:0] r;
        fl = 4'h0;
        if (f[30:23] == 8'hFF) begin
            if (f[22:0] != 23'd0) begin
                r         = BF16_CANON_NAN;
                fl[FL_NV] = !f[22];
            end else begin
                r = f[31:16];
            end
        end else begin
            nx  = f[15] || (f[14:0] != 15'd0);
            up  = f[15] && ((f[14:0] != 15'd0) || f[16]);
            mag = f[30:16] + {14'd0, up};
            if (mag[14:7] == 8'hFF) begin
                r         = {f[31], 15'h7F80};
                fl[FL_OF] = 1'b1;
                fl[FL_NX] = 1'b1;
            end else begin
                r         = {f[31], mag};
                fl[FL_NX] = nx;
                fl[FL_UF] = nx && (mag[14:7] == 8'h00);
            end
        end
        return {fl, r};
    endfunction

    logic [15:0] minmax;
    logic        minmax_nv;
    logic        cmp_true;
    logic        cmp_nv;
    logic [15:0] res_p0;
    logic [3:0]  flags_p0;
    logic [15:0] res_p1;
    logic [3:0]  flags_p1;
    logic        vld_p1;

    bf16_cmp_unit u_cmp (
        .a         (operand_a),
        .b         (operand_b),
        .op        (operation),
        .minmax    (minmax),
        .minmax_nv (minmax_nv),
        .cmp_true  (cmp_true),
        .cmp_nv    (cmp_nv)
    );

    // Stage p0: opcode mux over the combinational results.
    always_comb begin
        res_p0   = 16'h0000;
        flags_p0 = 4'h0;
        case (operation)
            OP_CVT: {flags_p0, res_p0} = cvt_round(operand_c);
            OP_MIN, OP_MAX: begin
                res_p0          = minmax;
                flags_p0[FL_NV] = minmax_nv;
            end
            OP_FEQ, OP_FLT, OP_FLE: begin
                res_p0          = {15'd0, cmp_true};
                flags_p0[FL_NV] = cmp_nv;
            end
            default: flags_p0[FL_NV] = 1'b1;
        endcase
    end

    // Stage p1: output registers; result and flags hold while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_p1   <= 16'h0000;
            flags_p1 <= 4'h0;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= enable;
            if (enable) begin
                res_p1   <= res_p0;
                flags_p1 <= flags_p0;
            end
        end
    end

    assign result = res_p1;
    assign fpcsr  = flags_p1;
    assign valid  = vld_p1;

endmodule

// File: tb/tb_bf16_accelerator_top.sv
// Bench for bf16_accelerator_top: directed vector table, multi-cycle sequences, randomized model check.
module tb_bf16_accelerator_top;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] operand_a;
    logic [15:0] operand_b;
    logic [31:0] operand_c;
    logic [3:0]  operation;
    logic [15:0] result;
    logic [3:0]  fpcsr;
    logic        valid;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bf16_accelerator_top dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .operand_c (operand_c),
        .operation (operation),
        .result    (result),
        .fpcsr     (fpcsr),
        .valid     (valid)
    );

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] c;
        logic [15:0] res;
        logic [3:0]  fl;
    } vec_t;

    localparam int NT = 24;
    vec_t tbl [NT];

    logic [15:0] specials [14] = '{16'h0000, 16'h8000, 16'h7F80, 16'hFF80, 16'h7FC0, 16'h7FA0,
                                   16'hFFC1, 16'h0001, 16'h8001, 16'h3F80, 16'hBF80, 16'h007F,
                                   16'h0080, 16'h7F7F};
    logic [3:0] ops [7] = '{4'h0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hF};

    task automatic check(input string name, input logic [15:0] exp_res,
                         input logic [3:0] exp_fl, input logic exp_vld);
        n_vec++;
        if (result !== exp_res || fpcsr !== exp_fl || valid !== exp_vld) begin
            n_bad++;
            $display("FAIL %s: got result=%h fpcsr=%h valid=%b, want result=%h fpcsr=%h valid=%b",
                     name, result, fpcsr, valid, exp_res, exp_fl, exp_vld);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] c, input logic en);
        @(negedge clk);
        operation = op;
        operand_a = a;
        operand_b = b;
        operand_c = c;
        enable    = en;
    endtask

    function automatic bit m_nan(input logic [15:0] x);
        return (x[14:7] == 8'hFF) && (x[6:0] != 7'd0);
    endfunction

    function automatic bit m_snan(input logic [15:0] x);
        return m_nan(x) && (x[6] == 1'b0);
    endfunction

    // Numeric value of a non-NaN bf16; infinity maps beyond the largest finite value.
    function automatic real to_real(input logic [15:0] x);
        int  e;
        real v;
        e = int'(x[14:7]);
        if (e == 0)
            v = real'(x[6:0]) * (2.0 ** (-133));
        else if (e == 255)
            v = 1.0e40;
        else
            v = real'(128 + int'(x[6:0])) * (2.0 ** (e - 134));
        return x[15] ? -v : v;
    endfunction

    function automatic logic [19:0] model(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic [31:0] c);
        real         ra;
        real         rb;
        bit          an;
        bit          bn;
        bit          sn;
        logic [15:0] r;
        logic [3:0]  fl;
        int          mag;
        int          q;
        int          rem;
        an = m_nan(a);
        bn = m_nan(b);
        sn = m_snan(a) || m_snan(b);
        ra = an ? 0.0 : to_real(a);
        rb = bn ? 0.0 : to_real(b);
        r  = 16'h0000;
        fl = 4'h0;
        case (op)
            4'h2, 4'h3: begin
                fl[3] = sn;
                if (an && bn)      r = 16'h7FC0;
                else if (an)       r = b;
                else if (bn)       r = a;
                else if (ra < rb)  r = (op == 4'h3) ? b : a;
                else if (rb < ra)  r = (op == 4'h3) ? a : b;
                else if (ra == 0.0) begin
                    if (op == 4'h2) r = (a[15] || b[15]) ? 16'h8000 : 16'h0000;
                    else            r = (a[15] && b[15]) ? 16'h8000 : 16'h0000;
                end else           r = a;
            end
            4'h4: begin
                r[0]  = !an && !bn && (ra == rb);
                fl[3] = sn;
            end
            4'h5: begin
                r[0]  = !an && !bn && (ra < rb);
                fl[3] = an || bn;
            end
            4'h6: begin
                r[0]  = !an && !bn && (ra <= rb);
                fl[3] = an || bn;
            end
            4'h0: begin
                if (c[30:23] == 8'hFF) begin
                    if (c[22:0] != 0) begin
                        r     = 16'h7FC0;
                        fl[3] = !c[22];
                    end else begin
                        r = c[31:16];
                    end
                end else begin
                    mag = int'({1'b0, c[30:0]});
                    q   = mag / 65536;
                    rem = mag % 65536;
                    if (rem > 32768 || (rem == 32768 && (q % 2) == 1)) q = q + 1;
                    if (q >= 32640) begin
                        r  = {c[31], 15'h7F80};
                        fl = 4'b0101;
                    end else begin
                        r     = {c[31], q[14:0]};
                        fl[0] = (rem != 0);
                        fl[1] = (rem != 0) && (q < 128);
                    end
                end
            end
            default: fl[3] = 1'b1;
        endcase
        return {fl, r};
    endfunction

    function automatic logic [15:0] pick16();
        if ($urandom_range(0, 2) == 0) return specials[$urandom_range(0, 13)];
        return 16'($urandom);
    endfunction

    initial begin
        logic [15:0] exp_r;
        logic [3:0]  exp_f;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] c;
        logic        en;

        tbl = '{
            '{4'h2, 16'h4000, 16'h3F80, 32'h0, 16'h3F80, 4'h0},
            '{4'h3, 16'h3555, 16'h3555, 32'h0, 16'h3555, 4'h0},
            '{4'h3, 16'h7F80, 16'h7FC0, 32'h0, 16'h7F80, 4'h0},
            '{4'h2, 16'h7FA0, 16'h3F80, 32'h0, 16'h3F80, 4'h8},
            '{4'h3, 16'h7FC1, 16'h7FA0, 32'h0, 16'h7FC0, 4'h8},
            '{4'h2, 16'h8000, 16'h0000, 32'h0, 16'h8000, 4'h0},
            '{4'h3, 16'h8000, 16'h0000, 32'h0, 16'h0000, 4'h0},
            '{4'h2, 16'h0040, 16'h0001, 32'h0, 16'h0001, 4'h0},
            '{4'h2, 16'hC000, 16'h4000, 32'h0, 16'hC000, 4'h0},
            '{4'h3, 16'h7F80, 16'h0080, 32'h0, 16'h7F80, 4'h0},
            '{4'h0, 16'h1234, 16'h5678, 32'h3F808000, 16'h3F80, 4'h1},
            '{4'h0, 16'h0000, 16'h0000, 32'h3F818000, 16'h3F82, 4'h1},
            '{4'h0, 16'h0000, 16'h0000, 32'h7F7FFFFF, 16'h7F80, 4'h5},
            '{4'h0, 16'h0000, 16'h0000, 32'h00000001, 16'h0000, 4'h3},
            '{4'h0, 16'h0000, 16'h0000, 32'h3F800000, 16'h3F80, 4'h0},
            '{4'h4, 16'h8000, 16'h0000, 32'h0, 16'h0001, 4'h0},
            '{4'h5, 16'h7FC0, 16'h3F80, 32'h0, 16'h0000, 4'h8},
            '{4'h4, 16'h7FC0, 16'h3F80, 32'h0, 16'h0000, 4'h0},
            '{4'hF, 16'h3F80, 16'h3F80, 32'h0, 16'h0000, 4'h8},
            '{4'h6, 16'h3F80, 16'h3F80, 32'h0, 16'h0001, 4'h0},
            '{4'h5, 16'h8000, 16'h0000, 32'h0, 16'h0000, 4'h0},
            '{4'h0, 16'h0000, 16'h0000, 32'hFF800000, 16'hFF80, 4'h0},
            '{4'h0, 16'h0000, 16'h0000, 32'h7F800001, 16'h7FC0, 4'h8},
            '{4'h5, 16'hBF80, 16'h0001, 32'h0, 16'h0001, 4'h0}
        };

        reset     = 1'b1;
        enable    = 1'b0;
        operation = 4'h0;
        operand_a = 16'h0;
        operand_b = 16'h0;
        operand_c = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 16'h0000, 4'h0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NT; i++) begin
            drive(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].c, 1'b1);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), tbl[i].res, tbl[i].fl, 1'b1);
        end

        // Back-to-back MINs, then idle cycles holding the last result.
        drive(4'h2, 16'h4000, 16'h3F80, 32'h0, 1'b1);
        @(posedge clk); #1; check("b2b_0", 16'h3F80, 4'h0, 1'b1);
        drive(4'h2, 16'hC000, 16'h4000, 32'h0, 1'b1);
        @(posedge clk); #1; check("b2b_1", 16'hC000, 4'h0, 1'b1);
        drive(4'h2, 16'h7FA0, 16'h0001, 32'h0, 1'b1);
        @(posedge clk); #1; check("b2b_2", 16'h0001, 4'h8, 1'b1);
        drive(4'h3, 16'h1111, 16'h2222, 32'h0, 1'b0);
        @(posedge clk); #1; check("idle_0", 16'h0001, 4'h8, 1'b0);
        @(posedge clk); #1; check("idle_1", 16'h0001, 4'h8, 1'b0);

        // Reset together with enable discards the issued operation.
        drive(4'h0, 16'h0, 16'h0, 32'h7F7FFFFF, 1'b1);
        @(posedge clk); #1; check("pre_rst", 16'h7F80, 4'h5, 1'b1);
        drive(4'h2, 16'h4000, 16'h3F80, 32'h0, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1; check("rst_en", 16'h0000, 4'h0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        exp_r = 16'h0000;
        exp_f = 4'h0;
        for (int i = 0; i < 600; i++) begin
            en = ($urandom_range(0, 3) != 0);
            op = ($urandom_range(0, 7) == 7) ? 4'($urandom) : ops[$urandom_range(0, 6)];
            a  = pick16();
            b  = ($urandom_range(0, 4) == 0) ? a : pick16();
            case ($urandom_range(0, 2))
                0:       c = $urandom;
                1:       c = {pick16(), 16'h8000};
                default: c = {pick16(), 16'($urandom)};
            endcase
            drive(op, a, b, c, en);
            @(posedge clk);
            #1;
            if (en) {exp_f, exp_r} = model(op, a, b, c);
            check($sformatf("rand%0d op=%h a=%h b=%h c=%h", i, op, a, b, c), exp_r, exp_f, en);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
